// File: rtl/phase_cal_pkg.sv
// Shared types and phase arithmetic for the phase calibration sequencer.
package phase_cal_pkg;

    localparam int unsigned NUM_PHASES = 56;
    localparam int unsigned PHASE_W    = 6;
    localparam int unsigned LEN_W      = PHASE_W + 1;

    typedef enum logic [3:0] {
        IDLE, TEST, WAIT_RES, STEP, WAIT_ADJ, SETTLE, EVAL, SEEK, SEEK_WAIT, DONE, FAIL
    } state_t;

    // Phase addition that wraps 55+1 back to 0; both operands are below NUM_PHASES.
    function automatic logic [PHASE_W-1:0] mod_add(input logic [PHASE_W-1:0] a,
                                                   input logic [PHASE_W-1:0] b);
        logic [LEN_W-1:0] sum;
        sum = LEN_W'(a) + LEN_W'(b);
        if (sum >= LEN_W'(NUM_PHASES)) sum = sum - LEN_W'(NUM_PHASES);
        return PHASE_W'(sum);
    endfunction

endpackage

// File: rtl/phase_cal_sequencer_if.sv
// Phase-adjust wrapper and link-test handshakes seen by the calibration sequencer.
interface phase_cal_sequencer_if;
    import phase_cal_pkg::*;

    logic               inc_trigger_out;
    logic               adj_idle_in;
    logic [PHASE_W-1:0] num_incs_in;
    logic               test_start_out;
    logic               test_valid_in;
    logic               test_pass_in;

    modport master (
        output inc_trigger_out, test_start_out,
        input  adj_idle_in, num_incs_in, test_valid_in, test_pass_in
    );

    modport slave (
        input  inc_trigger_out, test_start_out,
        output adj_idle_in, num_incs_in, test_valid_in, test_pass_in
    );

endinterface

// File: rtl/phase_run_tracker.sv
// Longest passing run over scored steps; earliest run wins ties, no wrap-around merge.
module phase_run_tracker
    import phase_cal_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               score,
    input  logic               pass,
    input  logic [PHASE_W-1:0] idx,
    output logic [PHASE_W-1:0] best_start,
    output logic [LEN_W-1:0]   best_len
);

    logic [PHASE_W-1:0] cur_start;
    logic [LEN_W-1:0]   cur_len;
    logic [PHASE_W-1:0] run_start_c;
    logic [LEN_W-1:0]   run_len_c;

    always_comb begin
        run_start_c = (cur_len == '0) ? idx : cur_start;
        run_len_c   = cur_len + LEN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (score) begin
            if (pass) begin
                cur_start <= run_start_c;
                cur_len   <= run_len_c;
                if (run_len_c > best_len) begin
                    best_len   <= run_len_c;
                    best_start <= run_start_c;
                end
            end else begin
                cur_len <= '0;
            end
        end
    end

endmodule

// File: rtl/phase_cal_sequencer.sv
// Sweeps all 56 phase steps, link-tests each, then seeks to the centre of the longest pass run.
// Optional per-step pass bitmap storage under PHASE_CAL_PASS_MAP_EN.
module phase_cal_sequencer
    import phase_cal_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned TEST_TIMEOUT  = 1024,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  start_in,
    phase_cal_sequencer_if.master bus,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  fail_out,
    output logic [PHASE_W-1:0]    best_phase_out,
    output logic [NUM_PHASES-1:0] pass_map_out
);

    localparam int unsigned CNT_MAX = (TEST_TIMEOUT > SETTLE_CYCLES) ? TEST_TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [PHASE_W-1:0] origin, cur_phase, step_idx, offset, seek_cnt;
    logic [RETRY_W-1:0] retry;
    logic               seeking;
    logic               inc_trigger, test_start, busy, done, fail;
    logic [PHASE_W-1:0] best_phase;
    logic [PHASE_W-1:0] best_start;
    logic [LEN_W-1:0]   best_len;

    logic               run_start_c, score_c, score_pass_c, adj_match_c, adj_miss_c;
    logic [PHASE_W-1:0] exp_phase_c, offset_c;

    assign bus.inc_trigger_out = inc_trigger;
    assign bus.test_start_out  = test_start;
    assign busy_out            = busy;
    assign done_out            = done;
    assign fail_out            = fail;
    assign best_phase_out      = best_phase;

    always_comb begin
        state_n      = state;
        run_start_c  = 1'b0;
        score_c      = 1'b0;
        score_pass_c = 1'b0;
        adj_match_c  = 1'b0;
        adj_miss_c   = 1'b0;
        exp_phase_c  = mod_add(cur_phase, PHASE_W'(1));
        offset_c     = best_start + PHASE_W'((best_len - LEN_W'(1)) >> 1);
        case (state)
            IDLE, DONE, FAIL: begin
                if (start_in) begin
                    run_start_c = 1'b1;
                    state_n     = TEST;
                end
            end
            TEST: state_n = WAIT_RES;
            WAIT_RES: begin
                if (bus.test_valid_in) begin
                    score_c      = 1'b1;
                    score_pass_c = bus.test_pass_in;
                    state_n      = STEP;
                end else if (cnt == CNT_W'(TEST_TIMEOUT - 1)) begin
                    score_c = 1'b1;
                    state_n = STEP;
                end
            end
            STEP: state_n = WAIT_ADJ;
            // adj_idle_in is stale for two cycles after the trigger edge
            WAIT_ADJ: begin
                if (cnt >= CNT_W'(2) && bus.adj_idle_in) begin
                    if (bus.num_incs_in == exp_phase_c) begin
                        adj_match_c = 1'b1;
                        state_n     = seeking ? SEEK_WAIT : SETTLE;
                    end else if (retry == RETRY_W'(MAX_RETRY)) begin
                        state_n = FAIL;
                    end else begin
                        adj_miss_c = 1'b1;
                        state_n    = STEP;
                    end
                end
            end
            SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1))
                    state_n = (step_idx == PHASE_W'(NUM_PHASES)) ? EVAL : TEST;
            end
            EVAL: begin
                if (best_len == '0)        state_n = FAIL;
                else if (offset_c == '0)   state_n = DONE;
                else                       state_n = SEEK;
            end
            SEEK:      state_n = (seek_cnt == offset) ? DONE : STEP;
            SEEK_WAIT: state_n = SEEK;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state       <= IDLE;
            cnt         <= '0;
            origin      <= '0;
            cur_phase   <= '0;
            step_idx    <= '0;
            offset      <= '0;
            seek_cnt    <= '0;
            retry       <= '0;
            seeking     <= 1'b0;
            inc_trigger <= 1'b0;
            test_start  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            best_phase  <= '0;
        end else begin
            state       <= state_n;
            cnt         <= (state_n != state) ? '0 : ((&cnt) ? cnt : cnt + CNT_W'(1));
            inc_trigger <= (state_n == STEP);
            test_start  <= (state_n == TEST);
            busy        <= !(state_n inside {IDLE, DONE, FAIL});
            done        <= (state_n == DONE);
            fail        <= (state_n == FAIL);
            if (run_start_c) begin
                origin     <= bus.num_incs_in;
                cur_phase  <= bus.num_incs_in;
                step_idx   <= '0;
                offset     <= '0;
                seek_cnt   <= '0;
                retry      <= '0;
                seeking    <= 1'b0;
                best_phase <= '0;
            end
            if (adj_match_c) begin
                cur_phase <= exp_phase_c;
                retry     <= '0;
                if (seeking) seek_cnt <= seek_cnt + PHASE_W'(1);
                else         step_idx <= step_idx + PHASE_W'(1);
            end
            if (adj_miss_c) retry <= retry + RETRY_W'(1);
            if (state == EVAL && best_len != '0) begin
                offset     <= offset_c;
                best_phase <= mod_add(origin, offset_c);
                seeking    <= 1'b1;
            end
        end
    end

    phase_run_tracker u_tracker (
        .clk        (clk),
        .rst        (rst_in),
        .clear      (run_start_c),
        .score      (score_c),
        .pass       (score_pass_c),
        .idx        (step_idx),
        .best_start (best_start),
        .best_len   (best_len)
    );

`ifdef PHASE_CAL_PASS_MAP_EN
    logic [NUM_PHASES-1:0] pass_map;

    always_ff @(posedge clk) begin
        if (rst_in || run_start_c) pass_map <= '0;
        else if (score_c)          pass_map[step_idx] <= score_pass_c;
    end

    assign pass_map_out = pass_map;
`else
    assign pass_map_out = '0;
`endif

endmodule

// File: tb/tb_phase_cal_sequencer.sv
// Randomized bench for phase_cal_sequencer with behavioural phase-wrapper and link-tester models.
module tb_phase_cal_sequencer;

    localparam int NPH       = 56;
    localparam int MAX_RETRY = 3;
    localparam int TMO       = 1024;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic        busy_out, done_out, fail_out;
    logic [5:0]  best_phase_out;
    logic [55:0] pass_map_out;

    phase_cal_sequencer_if bus();

    phase_cal_sequencer dut (
        .clk            (clk),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .bus            (bus),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .fail_out       (fail_out),
        .best_phase_out (best_phase_out),
        .pass_map_out   (pass_map_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // stimulus controls (written by the main sequence only)
    logic        load_phase = 1'b0;
    int          load_val   = 0;
    int          origin_tb  = 0;
    logic [55:0] pass_rel   = '0;
    int          skip_idx   = -1;
    int          drop_at    = 1 << 30;
    int          drops_base = 0;
    int          ndrops     = 0;

    // wrapper model state
    int   phase      = 0;
    int   inc_count  = 0;
    int   drops_done = 0;
    int   dbl_count  = 0;
    int   adj_cnt    = 0;
    logic inc_prev   = 1'b0;
    int   t_inc_log[$];

    // tester model state
    int test_count = 0;
    int resp_cnt   = 0;
    int t_test_log[$];

    always @(posedge clk) cyc++;

    // Phase-adjust wrapper: each trigger goes busy for a few cycles, then advances (unless dropped).
    always @(negedge clk) begin
        if (load_phase) phase = load_val;
        if (rst_in) begin
            adj_cnt         = 0;
            bus.adj_idle_in = 1'b1;
            inc_prev        = 1'b0;
        end else begin
            if (bus.inc_trigger_out) begin
                inc_count++;
                t_inc_log.push_back(cyc);
                if (inc_prev) dbl_count++;
                adj_cnt         = $urandom_range(1, 4);
                bus.adj_idle_in = 1'b0;
            end else if (adj_cnt > 0) begin
                adj_cnt--;
                if (adj_cnt == 0) begin
                    if (inc_count >= drop_at && (drops_done - drops_base) < ndrops) drops_done++;
                    else phase = (phase + 1) % NPH;
                    bus.adj_idle_in = 1'b1;
                end
            end
            inc_prev = bus.inc_trigger_out;
        end
        bus.num_incs_in = 6'(phase);
    end

    // Link tester: answers after a random latency with the verdict for the current relative step.
    always @(negedge clk) begin
        bus.test_valid_in = 1'b0;
        bus.test_pass_in  = 1'b0;
        if (rst_in) begin
            resp_cnt = 0;
        end else if (bus.test_start_out) begin
            test_count++;
            t_test_log.push_back(cyc);
            resp_cnt = (test_count == skip_idx) ? 0 : $urandom_range(1, 12);
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                bus.test_valid_in = 1'b1;
                bus.test_pass_in  = pass_rel[(phase - origin_tb + NPH) % NPH];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    task automatic load_origin(input int org, input logic [55:0] pat);
        @(posedge clk);
        load_val   = org;
        load_phase = 1'b1;
        @(posedge clk);
        load_phase = 1'b0;
        origin_tb  = org;
        pass_rel   = pat;
    endtask

    // Full calibration run compared against the longest-run rule applied to the pass pattern.
    task automatic run_cal(input int org, input logic [55:0] pat, input bit skip0,
                           input int drop_k, input int ndrop, input bit poke_start);
        int ib, tb0, qi, qt, bl, bs, l, off, bp;
        bit fin, exp_fail;
        logic [55:0] eff;
        load_origin(org, pat);
        ib         = inc_count;
        tb0        = test_count;
        qi         = t_inc_log.size();
        qt         = t_test_log.size();
        skip_idx   = skip0 ? test_count + 1 : -1;
        drop_at    = (ndrop > 0) ? ib + drop_k : (1 << 30);
        drops_base = drops_done;
        ndrops     = ndrop;
        pulse_start();
        fin = 1'b0;
        for (int c = 0; c < 20000 && !fin; c++) begin
            start_in = (poke_start && c == 500);
            @(negedge clk);
            if (done_out || fail_out) fin = 1'b1;
        end
        start_in = 1'b0;
        check("run_finished", 64'(fin), 64'd1);

        eff = pat;
        if (skip0) eff[0] = 1'b0;
        bl = 0;
        bs = 0;
        for (int s = 0; s < NPH; s++) begin
            if (eff[s] && (s == 0 || !eff[s-1])) begin
                l = 0;
                while (s + l < NPH && eff[s+l]) l++;
                if (l > bl) begin
                    bl = l;
                    bs = s;
                end
            end
        end
        exp_fail = (bl == 0) || (ndrop > MAX_RETRY);
        off      = exp_fail ? 0 : bs + (bl - 1) / 2;
        bp       = (org + off) % NPH;

        check("done_out", 64'(done_out), 64'(!exp_fail));
        check("fail_out", 64'(fail_out), 64'(exp_fail));
        check("busy_out", 64'(busy_out), 64'd0);
        check("best_phase", 64'(best_phase_out), exp_fail ? 64'd0 : 64'(bp));
        if (ndrop > MAX_RETRY) begin
            check("retry_incs", 64'(inc_count - ib), 64'(drop_k + MAX_RETRY));
        end else begin
            check("tests", 64'(test_count - tb0), 64'(NPH));
            check("incs", 64'(inc_count - ib), 64'(NPH + off + ndrop));
            check("final_phase", 64'(phase), exp_fail ? 64'(org) : 64'(bp));
`ifdef PHASE_CAL_PASS_MAP_EN
            check("pass_map", 64'(pass_map_out), 64'(eff));
`else
            check("pass_map", 64'(pass_map_out), 64'd0);
`endif
        end
        check("inc_width", 64'(dbl_count), 64'd0);
        if (skip0 && t_inc_log.size() > qi && t_test_log.size() > qt)
            check("timeout_lat", 64'(t_inc_log[qi] - t_test_log[qt]), 64'(TMO + 1));
        else if (skip0)
            check("timeout_seen", 64'd0, 64'd1);
    endtask

    function automatic logic [55:0] rand_pat();
        logic [55:0] p;
        int n, s, l;
        p = '0;
        n = $urandom_range(1, 3);
        for (int r = 0; r < n; r++) begin
            s = $urandom_range(0, NPH - 1);
            l = $urandom_range(1, 15);
            for (int k = s; k < s + l && k < NPH; k++) p[k] = 1'b1;
        end
        return p;
    endfunction

    task automatic check_all_reset(input string pfx);
        check({pfx, "_inc"},   64'(bus.inc_trigger_out), 64'd0);
        check({pfx, "_test"},  64'(bus.test_start_out),  64'd0);
        check({pfx, "_busy"},  64'(busy_out),            64'd0);
        check({pfx, "_done"},  64'(done_out),            64'd0);
        check({pfx, "_fail"},  64'(fail_out),            64'd0);
        check({pfx, "_best"},  64'(best_phase_out),      64'd0);
        check({pfx, "_map"},   64'(pass_map_out),        64'd0);
    endtask

    initial begin
        logic [55:0] pat;
        int ib, tb0;
        rst_in   = 1'b1;
        start_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_reset("rst");
        rst_in = 1'b0;
        repeat (2) @(negedge clk);

        pat = '0;
        for (int i = 20; i <= 29; i++) pat[i] = 1'b1;
        run_cal(10, pat, 1'b0, 0, 0, 1'b0);

        run_cal(7, 56'd0, 1'b0, 0, 0, 1'b0);

        pat = '0;
        for (int i = 5; i <= 7; i++)   pat[i] = 1'b1;
        for (int i = 30; i <= 32; i++) pat[i] = 1'b1;
        run_cal(53, pat, 1'b0, 0, 0, 1'b0);

        pat = '0;
        for (int i = 40; i <= 50; i++) pat[i] = 1'b1;
        run_cal(30, pat, 1'b0, 5, 1, 1'b0);
        run_cal(2, pat, 1'b0, 5, 4, 1'b0);

        pat = '0;
        for (int i = 0; i <= 8; i++) pat[i] = 1'b1;
        run_cal(0, pat, 1'b1, 0, 0, 1'b0);

        run_cal(int'($urandom_range(0, 55)), rand_pat(), 1'b0, 0, 0, 1'b1);
        for (int r = 0; r < 3; r++)
            run_cal(int'($urandom_range(0, 55)), rand_pat(), 1'b0, 0, 0, 1'b0);

        // reset while the sequencer is settling after an increment
        load_origin(int'($urandom_range(0, 55)), rand_pat());
        ib = inc_count;
        pulse_start();
        for (int c = 0; c < 3000 && (inc_count - ib) < 3; c++) @(negedge clk);
        repeat (20) @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        check_all_reset("mid_rst");
        rst_in = 1'b0;
        ib  = inc_count;
        tb0 = test_count;
        repeat (10) @(negedge clk);
        check("post_rst_busy", 64'(busy_out), 64'd0);
        check("post_rst_quiet", 64'((inc_count - ib) + (test_count - tb0)), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_cal_sequencer.md
PHASE_CAL_SEQUENCER -- requirements
Module: phase_cal_sequencer

Interface
REQ-001 SETTLE_CYCLES, 64, idle cycles after each phase step before a link test.
REQ-002 TEST_TIMEOUT, 1024, cycles to wait for test_valid_in before the step is scored as fail.
REQ-003 MAX_RETRY, 3, re-issues allowed for a step whose num_incs_in did not advance.
REQ-004 clk  in  1  system clock, same clock as the phase-adjust wrapper's psclk.
REQ-005 rst_in  in  1  synchronous, active-high reset.
REQ-006 start_in  in  1  single-cycle calibration request.
REQ-007 inc_trigger_out  out  1  rising edge requests one phase increment.
REQ-008 adj_idle_in  in  1  wrapper idle (high when not incrementing).
REQ-009 num_incs_in  in  6  wrapper phase count, 0..55.
REQ-010 test_start_out  out  1  single-cycle link-test request.
REQ-011 test_valid_in / test_pass_in  in  1/1  test result strobe and verdict.
REQ-012 busy_out, done_out, fail_out  out  1 each  status; done_out/fail_out sticky until next start.
REQ-013 best_phase_out  out  6  selected absolute phase, 0..55.
REQ-014 pass_map_out  out  56  per-step pass bitmap, bit i = relative step i.

Function
REQ-015 States: IDLE, TEST, WAIT_RES, STEP, WAIT_ADJ, SETTLE, EVAL, SEEK, SEEK_WAIT, DONE, FAIL.
REQ-016 IDLE/DONE/FAIL + start_in: latch origin=num_incs_in, clear step index i, run trackers, retry count; go TEST; start_in ignored while busy_out=1.
REQ-017 TEST: assert test_start_out one cycle, go WAIT_RES with timeout counter cleared.
REQ-018 WAIT_RES: test_valid_in scores step i with test_pass_in; TEST_TIMEOUT expiry scores fail; go STEP.
REQ-019 STEP: inc_trigger_out high exactly one cycle, low otherwise; go WAIT_ADJ.
REQ-020 WAIT_ADJ: ignore adj_idle_in for 2 cycles, then on adj_idle_in=1 compare num_incs_in to expected (origin+i+1 mod 56).
REQ-021 Match: i<=i+1, go SETTLE; mismatch: retry++ and re-enter STEP; retry exceeding MAX_RETRY: go FAIL.
REQ-022 SETTLE: count SETTLE_CYCLES, then TEST if i<56 else EVAL; after 56 steps phase equals origin.
REQ-023 Run tracking: pass extends current run (start=i when length 0); fail zeroes it; best updated only when current length strictly exceeds best (earliest run wins ties); no wrap-around merge.
REQ-024 EVAL: best_len=0 go FAIL; else offset=best_start+(best_len-1)/2, best_phase_out=(origin+offset) mod 56, go SEEK (or DONE if offset=0).
REQ-025 SEEK/SEEK_WAIT: issue offset increments using STEP/WAIT_ADJ handshake and retry rules; then DONE.
REQ-026 All phase arithmetic 6-bit modulo 56 (55+1=0); counters sized for parameters without overflow.
REQ-027 busy_out=1 in every state except IDLE, DONE, FAIL; done_out=1 only in DONE, fail_out=1 only in FAIL.

Reset
REQ-028 rst_in at any cycle, including mid-sweep: state IDLE, inc_trigger_out=0, test_start_out=0, busy_out/done_out/fail_out=0, best_phase_out=0, pass_map_out=0, all counters 0.
REQ-029 A test_valid_in or adj_idle_in transition in the reset cycle is discarded.

Configuration
REQ-030 PHASE_CAL_PASS_MAP_EN defined: pass_map_out bit i written at scoring, cleared at start.
REQ-031 PHASE_CAL_PASS_MAP_EN undefined: no bitmap storage, pass_map_out constant 0, all other behaviour identical.

Structure
REQ-032 Package phase_cal_pkg: state enum, NUM_PHASES=56, PHASE_W=6, modulo-56 add function.
REQ-033 Sub-module phase_run_tracker: longest-run start/length over scored steps, clear/score inputs.

Verification
REQ-034 Origin 10, pass steps 20..29 only -> 56 tests, offset 24, best_phase_out=34, 24 seek pulses, done_out=1.
REQ-035 All steps fail -> fail_out=1 after 56 steps, zero seek pulses, best_phase_out=0.
REQ-036 Model drops one increment (num_incs_in unchanged) -> one retry, calibration completes; drop 4 times -> FAIL.
REQ-037 Runs 5..7 and 30..32 (equal length) -> best_start=5, offset 6; origin 53 -> best_phase_out=3 (wrap).
REQ-038 No test_valid_in at step 0 -> scored fail after 1024 cycles; rst_in asserted mid-SETTLE -> all outputs reset next cycle.
